// File: rtl/eu_result_buffer.sv
// Result store for one exec unit: tagged ALU results served to op0/op1/foreign lookups.
// Ports: res_* write handshake, op0/op1/fop lookups (req/uid -> data/success), occupancy_o.
module eu_result_buffer #(
  parameter int EU_IDX = 0,
  parameter int DEPTH  = 8,
  parameter int UID_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [UID_W-1:0]           res_uid_i,
  input  logic [DATA_W-1:0]          res_data_i,
  input  logic [1:0]                 res_nreads_i,
  input  logic                       op0_req_i,
  input  logic [UID_W-1:0]           op0_uid_i,
  output logic [DATA_W-1:0]          op0_data_o,
  output logic                       op0_success_o,
  input  logic                       op1_req_i,
  input  logic [UID_W-1:0]           op1_uid_i,
  output logic [DATA_W-1:0]          op1_data_o,
  output logic                       op1_success_o,
  input  logic                       fop_req_i,
  input  logic [UID_W-1:0]           fop_uid_i,
  output logic [DATA_W-1:0]          fop_data_o,
  output logic                       fop_success_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  // A malformed configuration never accepts results.
  localparam bit CFG_OK = (EU_IDX >= 0) && (DEPTH >= 2);

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [UID_W-1:0]  uid_q   [DEPTH];
  logic [UID_W-1:0]  uid_d   [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [1:0]        cnt_q   [DEPTH];
  logic [1:0]        cnt_d   [DEPTH];

  logic [DEPTH-1:0] hit0;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hitf;
  logic [DEPTH-1:0] wmatch;
  logic             any_match;
  logic             found;
  logic [IW-1:0]    alloc_idx;
  logic [CW-1:0]    occ;
  logic             accept;

  always_comb begin
    hit0          = '0;
    hit1          = '0;
    hitf          = '0;
    wmatch        = '0;
    op0_data_o    = '0;
    op1_data_o    = '0;
    fop_data_o    = '0;
    occ           = '0;
    found         = 1'b0;
    alloc_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit0[i]   = op0_req_i & valid_q[i] & (uid_q[i] == op0_uid_i);
      hit1[i]   = op1_req_i & valid_q[i] & (uid_q[i] == op1_uid_i);
      hitf[i]   = fop_req_i & valid_q[i] & (uid_q[i] == fop_uid_i);
      wmatch[i] = valid_q[i] & (uid_q[i] == res_uid_i);
      // uids are unique among valid entries, so OR-ing is a one-hot mux
      if (hit0[i]) op0_data_o = op0_data_o | data_q[i];
      if (hit1[i]) op1_data_o = op1_data_o | data_q[i];
      if (hitf[i]) fop_data_o = fop_data_o | data_q[i];
      occ = occ + {{(CW-1){1'b0}}, valid_q[i]};
      if (!valid_q[i] && !found) begin
        found     = 1'b1;
        alloc_idx = IW'(i);
      end
    end
    op0_success_o = |hit0;
    op1_success_o = |hit1;
    fop_success_o = |hitf;
    any_match     = |wmatch;
    occupancy_o   = occ;
    res_ready_o   = CFG_OK && ((occ != CW'(DEPTH)) || any_match);
    accept        = res_valid_i & res_ready_o & ~flush_i;
  end

  always_comb begin
    logic [1:0] nh;
    nh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      uid_d[i]   = uid_q[i];
      data_d[i]  = data_q[i];
      cnt_d[i]   = cnt_q[i];
      nh = {1'b0, hit0[i]} + {1'b0, hit1[i]} + {1'b0, hitf[i]};
      if (nh != 2'd0) begin
        if (cnt_q[i] > nh) begin
          cnt_d[i] = cnt_q[i] - nh;
        end else begin
          cnt_d[i]   = 2'd0;
          valid_d[i] = 1'b0;
        end
      end
      // in-place rewrite wins over this cycle's reads of the old value
      if (accept && wmatch[i]) begin
        valid_d[i] = (res_nreads_i != 2'd0);
        data_d[i]  = res_data_i;
        cnt_d[i]   = res_nreads_i;
      end
      if (accept && !any_match && found &&
          (alloc_idx == IW'(i)) && (res_nreads_i != 2'd0)) begin
        valid_d[i] = 1'b1;
        uid_d[i]   = res_uid_i;
        data_d[i]  = res_data_i;
        cnt_d[i]   = res_nreads_i;
      end
      if (flush_i) valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        uid_q[i]   <= '0;
        data_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        uid_q[i]   <= uid_d[i];
        data_q[i]  <= data_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_eu_result_buffer.sv
// Bench for eu_result_buffer: directed scenarios then random traffic vs a uid-keyed model.
// Ports: none.
module tb_eu_result_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [3:0]  res_uid_i;
  logic [31:0] res_data_i;
  logic [1:0]  res_nreads_i;
  logic        op0_req_i, op1_req_i, fop_req_i;
  logic [3:0]  op0_uid_i, op1_uid_i, fop_uid_i;
  logic [31:0] op0_data_o, op1_data_o, fop_data_o;
  logic        op0_success_o, op1_success_o, fop_success_o;
  logic [3:0]  occupancy_o;

  int n_total = 0;
  int n_pass  = 0;

  // model: uid -> stored data and remaining reader count
  logic [31:0] m_data [int];
  int          m_cnt  [int];

  always #5 clk = ~clk;

  eu_result_buffer #(.EU_IDX(0), .DEPTH(8), .UID_W(4), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_uid_i(res_uid_i), .res_data_i(res_data_i),
    .res_nreads_i(res_nreads_i),
    .op0_req_i(op0_req_i), .op0_uid_i(op0_uid_i),
    .op0_data_o(op0_data_o), .op0_success_o(op0_success_o),
    .op1_req_i(op1_req_i), .op1_uid_i(op1_uid_i),
    .op1_data_o(op1_data_o), .op1_success_o(op1_success_o),
    .fop_req_i(fop_req_i), .fop_uid_i(fop_uid_i),
    .fop_data_o(fop_data_o), .fop_success_o(fop_success_o),
    .occupancy_o(occupancy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_port(input string tag, input logic req,
                          input logic [3:0] uid, input logic succ,
                          input logic [31:0] data);
    logic        es;
    logic [31:0] ed;
    es = req && m_cnt.exists(int'(uid));
    ed = es ? m_data[int'(uid)] : 32'h0;
    chk({tag, "_success"}, 64'(succ), 64'(es));
    chk({tag, "_data"}, 64'(data), 64'(ed));
  endtask

  task automatic model_clear();
    m_data.delete();
    m_cnt.delete();
  endtask

  // Called at a negedge: drive, check combinational view, update model,
  // then advance to the next negedge.
  task automatic step(input bit fl, input bit rv, input int ru,
                      input logic [31:0] rd, input int rn,
                      input bit r0, input int u0,
                      input bit r1, input int u1,
                      input bit rf, input int uf);
    bit eready;
    bit acc;
    int hits [int];
    flush_i      = fl;
    res_valid_i  = rv;
    res_uid_i    = 4'(ru);
    res_data_i   = rd;
    res_nreads_i = 2'(rn);
    op0_req_i = r0; op0_uid_i = 4'(u0);
    op1_req_i = r1; op1_uid_i = 4'(u1);
    fop_req_i = rf; fop_uid_i = 4'(uf);
    #2;
    eready = (m_cnt.num() != 8) || m_cnt.exists(ru);
    chk("ready", 64'(res_ready_o), 64'(eready));
    chk("occupancy", 64'(occupancy_o), 64'(m_cnt.num()));
    chk_port("op0", r0, 4'(u0), op0_success_o, op0_data_o);
    chk_port("op1", r1, 4'(u1), op1_success_o, op1_data_o);
    chk_port("fop", rf, 4'(uf), fop_success_o, fop_data_o);
    acc = rv && eready && !fl;
    if (fl) begin
      model_clear();
    end else begin
      if (r0 && m_cnt.exists(u0)) hits[u0] = hits.exists(u0) ? hits[u0] + 1 : 1;
      if (r1 && m_cnt.exists(u1)) hits[u1] = hits.exists(u1) ? hits[u1] + 1 : 1;
      if (rf && m_cnt.exists(uf)) hits[uf] = hits.exists(uf) ? hits[uf] + 1 : 1;
      foreach (hits[u]) begin
        if (!(acc && u == ru)) begin
          m_cnt[u] = m_cnt[u] - hits[u];
          if (m_cnt[u] <= 0) begin
            m_cnt.delete(u);
            m_data.delete(u);
          end
        end
      end
      if (acc) begin
        if (rn == 0) begin
          m_cnt.delete(ru);
          m_data.delete(ru);
        end else begin
          m_cnt[ru]  = rn;
          m_data[ru] = rd;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int u, input logic [31:0] d, input int n);
    step(0, 1, u, d, n, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_view(input string tag);
    chk({tag, "_ready"}, 64'(res_ready_o), 64'd1);
    chk({tag, "_occ"}, 64'(occupancy_o), 64'd0);
    chk({tag, "_op0"}, 64'({op0_success_o, op0_data_o}), 64'd0);
    chk({tag, "_op1"}, 64'({op1_success_o, op1_data_o}), 64'd0);
    chk({tag, "_fop"}, 64'({fop_success_o, fop_data_o}), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    flush_i = 0; res_valid_i = 0; res_uid_i = 0;
    res_data_i = 0; res_nreads_i = 0;
    op0_req_i = 1; op0_uid_i = 0;
    op1_req_i = 1; op1_uid_i = 1;
    fop_req_i = 1; fop_uid_i = 2;
    #1;
    chk_reset_view("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // single reader, freed after one hit
    wr(3, 32'hA5, 1);
    step(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);

    // two readers in the same cycle
    step(0, 1, 5, 32'h55, 2, 1, 5, 0, 0, 1, 5);
    step(0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 5);
    idle();

    // fill, stall, drain one entry with three hits
    for (int u = 0; u < 8; u++) wr(u, 32'h100 + u, 3);
    wr(9, 32'h99, 1);
    step(0, 1, 9, 32'h99, 1, 1, 2, 1, 2, 1, 2);
    wr(9, 32'h99, 1);
    step(0, 0, 0, 0, 0, 1, 9, 1, 6, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // in-place overwrite
    wr(2, 32'h11, 3);
    wr(2, 32'h22, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    idle();

    // written value is invisible in its write cycle
    step(0, 1, 4, 32'h44, 1, 0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);

    // flush overrides a concurrent write
    for (int u = 10; u < 14; u++) wr(u, 32'hF0 + u, 2);
    step(1, 1, 14, 32'hEE, 1, 1, 10, 0, 0, 0, 0);
    idle();

    // nreads=0 invalidates a matching entry
    wr(7, 32'h77, 2);
    wr(7, 32'h78, 0);
    step(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);

    // reset mid-stream
    wr(1, 32'h1, 2);
    wr(6, 32'h6, 2);
    op0_req_i = 1; op0_uid_i = 1;
    op1_req_i = 1; op1_uid_i = 6;
    fop_req_i = 1; fop_uid_i = 1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_view("midreset");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9), $urandom, $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 9),
           $urandom_range(0, 1), $urandom_range(0, 9),
           $urandom_range(0, 1), $urandom_range(0, 9));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
